// File: rtl/mem_arb_pkg.sv
// Shared definitions for the IF/DM byte-memory port arbiter: state encoding, size codes,
// requester ids and the size-to-byte-count helper.
package mem_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_XFER = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic RQ_IF = 1'b0;
    localparam logic RQ_DM = 1'b1;

    // Size code 11 is not an error: it behaves as a full word.
    function automatic logic [2:0] size_to_nbytes(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            SZ_W:    return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Byte sequencer: walks one access a byte per cycle, wrapping the address, driving the
// store byte and assembling load bytes into the granted port's little-endian lane.
module mem_byte_seq
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int WORD_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    xfer,
    input  logic                    start_id,
    input  logic                    start_we,
    input  logic [ADDR_W-1:0]       start_addr,
    input  logic [2:0]              start_nbytes,
    input  logic [8*WORD_BYTES-1:0] start_wdata,
    input  logic                    id,
    output logic                    last,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_we,
    output logic [7:0]              mem_wdata,
    input  logic [7:0]              mem_rdata,
    output logic [8*WORD_BYTES-1:0] if_rdata,
    output logic [8*WORD_BYTES-1:0] dm_rdata
);

    logic [1:0]              cnt_r;
    logic [2:0]              nbytes_r;
    logic                    we_r;
    logic [ADDR_W-1:0]       addr_r;
    logic                    mem_we_r;
    logic [7:0]              mem_wdata_r;
    logic [8*WORD_BYTES-9:0] wdata_r;
    logic [8*WORD_BYTES-1:0] if_rdata_r;
    logic [8*WORD_BYTES-1:0] dm_rdata_r;

    assign last      = ({1'b0, cnt_r} == (nbytes_r - 3'd1));
    assign mem_addr  = addr_r;
    assign mem_we    = mem_we_r;
    assign mem_wdata = mem_wdata_r;
    assign if_rdata  = if_rdata_r;
    assign dm_rdata  = dm_rdata_r;

    // Byte counter, address and store-byte pipeline; the strobe drops on the edge leaving XFER.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r       <= 2'd0;
            nbytes_r    <= 3'd0;
            we_r        <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
            mem_we_r    <= 1'b0;
            mem_wdata_r <= 8'h00;
            wdata_r     <= {(8*WORD_BYTES-8){1'b0}};
        end else if (start) begin
            cnt_r       <= 2'd0;
            nbytes_r    <= start_nbytes;
            we_r        <= start_we;
            addr_r      <= start_addr;
            mem_we_r    <= start_we;
            mem_wdata_r <= start_wdata[7:0];
            wdata_r     <= start_wdata[8*WORD_BYTES-1:8];
        end else if (xfer && !last) begin
            cnt_r       <= cnt_r + 2'd1;
            addr_r      <= addr_r + ADDR_W'(1'b1);
            mem_we_r    <= we_r;
            mem_wdata_r <= wdata_r[7:0];
            wdata_r     <= {8'h00, wdata_r[8*WORD_BYTES-9:8]};
        end else begin
            mem_we_r    <= 1'b0;
        end
    end

    // Per-port read lanes: cleared only when that port is granted, so the other port's value persists.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rdata_r <= {(8*WORD_BYTES){1'b0}};
            dm_rdata_r <= {(8*WORD_BYTES){1'b0}};
        end else if (start) begin
            if (start_id == RQ_DM) begin
                dm_rdata_r <= {(8*WORD_BYTES){1'b0}};
            end else begin
                if_rdata_r <= {(8*WORD_BYTES){1'b0}};
            end
        end else if (xfer && !we_r) begin
            if (id == RQ_DM) begin
                dm_rdata_r[{cnt_r, 3'b000} +: 8] <= mem_rdata;
            end else begin
                if_rdata_r[{cnt_r, 3'b000} +: 8] <= mem_rdata;
            end
        end else begin
            if_rdata_r <= if_rdata_r;
            dm_rdata_r <= dm_rdata_r;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one byte-wide memory between instruction fetch and load/store.
// Fixed DM-over-IF priority by default; define MEM_ARB_RR_EN for round-robin arbitration.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int WORD_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req,
    input  logic [ADDR_W-1:0]       if_addr,
    output logic [8*WORD_BYTES-1:0] if_rdata,
    output logic                    if_done,
    input  logic                    dm_req,
    input  logic                    dm_we,
    input  logic [1:0]              dm_size,
    input  logic [ADDR_W-1:0]       dm_addr,
    input  logic [8*WORD_BYTES-1:0] dm_wdata,
    output logic [8*WORD_BYTES-1:0] dm_rdata,
    output logic                    dm_done,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_we,
    output logic [7:0]              mem_wdata,
    input  logic [7:0]              mem_rdata,
    output logic                    busy
);

    state_t state_r;
    state_t state_nxt_s;
    logic   grant_s;
    logic   gnt_id_s;
    logic   gnt_id_r;
    logic   if_done_r;
    logic   dm_done_r;
    logic   busy_r;
    logic   xfer_s;
    logic   last_s;
    logic   is_dm_s;
`ifdef MEM_ARB_RR_EN
    logic   last_dm_r;
`endif

    assign xfer_s  = (state_r == ST_XFER);
    assign is_dm_s = (gnt_id_s == RQ_DM);
    assign if_done = if_done_r;
    assign dm_done = dm_done_r;
    assign busy    = busy_r;

    // Requester selection; a losing request is simply left pending.
    always_comb begin
        gnt_id_s = RQ_IF;
`ifdef MEM_ARB_RR_EN
        if (dm_req && if_req) begin
            gnt_id_s = last_dm_r ? RQ_IF : RQ_DM;
        end else if (dm_req) begin
            gnt_id_s = RQ_DM;
        end else begin
            gnt_id_s = RQ_IF;
        end
`else
        if (dm_req) begin
            gnt_id_s = RQ_DM;
        end else begin
            gnt_id_s = RQ_IF;
        end
`endif
    end

    // IDLE -> XFER -> DONE -> IDLE; grants only happen from IDLE.
    always_comb begin
        state_nxt_s = state_r;
        grant_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (dm_req || if_req) begin
                    grant_s     = 1'b1;
                    state_nxt_s = ST_XFER;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_XFER;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, grant owner and registered done/busy flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            gnt_id_r  <= RQ_IF;
            if_done_r <= 1'b0;
            dm_done_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            gnt_id_r  <= grant_s ? gnt_id_s : gnt_id_r;
            if_done_r <= xfer_s && last_s && (gnt_id_r == RQ_IF);
            dm_done_r <= xfer_s && last_s && (gnt_id_r == RQ_DM);
            busy_r    <= (state_nxt_s != ST_IDLE);
        end
    end

`ifdef MEM_ARB_RR_EN
    // Remembers who was granted last; resets to "IF last" so DM wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_dm_r <= 1'b0;
        end else if (grant_s) begin
            last_dm_r <= is_dm_s;
        end else begin
            last_dm_r <= last_dm_r;
        end
    end
`endif

    mem_byte_seq #(
        .ADDR_W     (ADDR_W),
        .WORD_BYTES (WORD_BYTES)
    ) u_seq (
        .clk          (clk),
        .rst          (rst),
        .start        (grant_s),
        .xfer         (xfer_s),
        .start_id     (gnt_id_s),
        .start_we     (is_dm_s && dm_we),
        .start_addr   (is_dm_s ? dm_addr : if_addr),
        .start_nbytes (is_dm_s ? size_to_nbytes(dm_size) : 3'd4),
        .start_wdata  (is_dm_s ? dm_wdata : {(8*WORD_BYTES){1'b0}}),
        .id           (gnt_id_r),
        .last         (last_s),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .if_rdata     (if_rdata),
        .dm_rdata     (dm_rdata)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic checked against a byte-array reference model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [7:0]  if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        dm_req;
    logic        dm_we;
    logic [1:0]  dm_size;
    logic [7:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;

    logic [7:0]  mem     [0:255];
    logic [7:0]  ref_mem [0:255];

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          last_dm;
    logic [31:0] exp_if;
    logic [31:0] exp_dm;

    typedef struct {
        logic        dm;
        logic        we;
        logic [1:0]  size;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          lat;
    } vec_t;
    vec_t vecs [11];

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_done(dm_done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int nb(input logic [1:0] s);
        return (s == 2'b00) ? 1 : ((s == 2'b01) ? 2 : 4);
    endfunction

    function automatic logic [31:0] model_load(input logic [7:0] a, input int n);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[8'(a + i)];
        return v;
    endfunction

    task automatic model_store(input logic [7:0] a, input int n, input logic [31:0] wd);
        for (int i = 0; i < n; i++) ref_mem[8'(a + i)] = wd[8*i +: 8];
    endtask

    function automatic bit model_dm_wins_tie();
`ifdef MEM_ARB_RR_EN
        return !last_dm;
`else
        return 1'b1;
`endif
    endfunction

    task automatic wait_idle();
        int g;
        g = 0;
        @(negedge clk);
        while (busy && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'h0);
    endtask

    task automatic do_txn(input string name, input logic dm, input logic we, input logic [1:0] size,
                          input logic [7:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input int exp_lat);
        int cyc, n, we_hits, addr_err;
        bit seen;
        n = dm ? nb(size) : 4;
        wait_idle();
        if (dm) begin
            dm_req = 1'b1; dm_we = we; dm_size = size; dm_addr = addr; dm_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        cyc = 0; seen = 1'b0; we_hits = 0; addr_err = 0;
        while (!seen && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (mem_we) we_hits++;
            if (cyc <= n && mem_addr !== 8'(addr + cyc - 1)) addr_err++;
            seen = dm ? dm_done : if_done;
        end
        dm_req = 1'b0;
        if_req = 1'b0;
        check({name, "_lat"}, 32'(cyc), 32'(exp_lat));
        check({name, "_addr_seq"}, 32'(addr_err), 32'h0);
        check({name, "_we_cnt"}, 32'(we_hits), (dm && we) ? 32'(n) : 32'h0);
        if (dm) begin
            check({name, "_dm_rdata"}, dm_rdata, exp_rd);
            check({name, "_if_hold"}, if_rdata, exp_if);
            exp_dm = exp_rd;
        end else begin
            check({name, "_if_rdata"}, if_rdata, exp_rd);
            check({name, "_dm_hold"}, dm_rdata, exp_dm);
            exp_if = exp_rd;
        end
        @(posedge clk); #1;
        check({name, "_done_pulse"}, 32'({if_done, dm_done}), 32'h0);
        last_dm = dm;
    endtask

    task automatic tie_seq(input string name);
        bit dm_first;
        int c, if_at, dm_at;
        dm_first = model_dm_wins_tie();
        wait_idle();
        if_req = 1'b1; if_addr = 8'h04;
        dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'b10; dm_addr = 8'h10; dm_wdata = 32'h0;
        c = 0; if_at = -1; dm_at = -1;
        while ((if_at < 0 || dm_at < 0) && c < 30) begin
            @(posedge clk); #1;
            c++;
            if (if_done) begin if_at = c; if_req = 1'b0; end
            if (dm_done) begin dm_at = c; dm_req = 1'b0; end
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        check({name, "_dm_lat"}, 32'(dm_at), dm_first ? 32'd5 : 32'd11);
        check({name, "_if_lat"}, 32'(if_at), dm_first ? 32'd11 : 32'd5);
        exp_dm = model_load(8'h10, 4);
        exp_if = model_load(8'h04, 4);
        check({name, "_dm_rdata"}, dm_rdata, exp_dm);
        check({name, "_if_rdata"}, if_rdata, exp_if);
        last_dm = !dm_first;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, busy_cnt, done_cnt;
        logic [31:0] wd;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h93; mem[1] = 8'h02; mem[2] = 8'h10; mem[3] = 8'h00;
        mem[4] = 8'h13; mem[5] = 8'h05; mem[6] = 8'h30; mem[7] = 8'h00;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];

        rst = 1'b1; if_req = 1'b0; if_addr = 8'h00;
        dm_req = 1'b0; dm_we = 1'b0; dm_size = 2'b00; dm_addr = 8'h00; dm_wdata = 32'h0;
        last_dm = 1'b0; exp_if = 32'h0; exp_dm = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_dm_rdata", dm_rdata, 32'h0);
        check("rst_done", 32'({if_done, dm_done}), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;

        vecs[0]  = '{1'b0, 1'b0, 2'b10, 8'h00, 32'h0,        32'h00100293, 5};
        vecs[1]  = '{1'b1, 1'b1, 2'b10, 8'h10, 32'hDEADBEEF, 32'h00000000, 5};
        vecs[2]  = '{1'b1, 1'b0, 2'b10, 8'h10, 32'h0,        32'hDEADBEEF, 5};
        vecs[3]  = '{1'b1, 1'b1, 2'b00, 8'hFF, 32'h00000034, 32'h00000000, 2};
        vecs[4]  = '{1'b1, 1'b1, 2'b00, 8'h00, 32'hFFFFFF12, 32'h00000000, 2};
        vecs[5]  = '{1'b1, 1'b0, 2'b01, 8'hFF, 32'h0,        32'h00001234, 3};
        vecs[6]  = '{1'b1, 1'b0, 2'b00, 8'hFF, 32'h0,        32'h00000034, 2};
        vecs[7]  = '{1'b1, 1'b1, 2'b10, 8'hFE, 32'h44332211, 32'h00000000, 5};
        vecs[8]  = '{1'b1, 1'b0, 2'b11, 8'hFE, 32'h0,        32'h44332211, 5};
        vecs[9]  = '{1'b1, 1'b1, 2'b01, 8'h20, 32'hCAFEBABE, 32'h00000000, 3};
        vecs[10] = '{1'b1, 1'b0, 2'b10, 8'h20, 32'h0,        32'h0000BABE, 5};

        for (int i = 0; i < 11; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i].dm, vecs[i].we, vecs[i].size, vecs[i].addr,
                   vecs[i].wdata, vecs[i].exp_rd, vecs[i].lat);
            if (vecs[i].dm && vecs[i].we) model_store(vecs[i].addr, nb(vecs[i].size), vecs[i].wdata);
        end
        check("st_word_b0", 32'(mem[8'h10]), 32'h000000EF);
        check("st_word_b1", 32'(mem[8'h11]), 32'h000000BE);
        check("st_word_b2", 32'(mem[8'h12]), 32'h000000AD);
        check("st_word_b3", 32'(mem[8'h13]), 32'h000000DE);
        check("st_wrap_b2", 32'(mem[8'h00]), 32'h00000033);

        tie_seq("tie1");
        do_txn("fetch_mid", 1'b0, 1'b0, 2'b10, 8'h04, 32'h0, model_load(8'h04, 4), 5);
        tie_seq("tie2");

        // Fetch request withdrawn right after the grant still completes exactly once.
        wait_idle();
        if_req = 1'b1; if_addr = 8'h04;
        @(posedge clk); #1;
        if_req = 1'b0;
        c = 1;
        while (!if_done && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        check("drop_if_lat", 32'(c), 32'd5);
        check("drop_if_rdata", if_rdata, model_load(8'h04, 4));
        exp_if = model_load(8'h04, 4);
        last_dm = 1'b0;
        busy_cnt = 0;
        @(posedge clk);
        repeat (8) begin
            @(posedge clk); #1;
            if (busy || if_done) busy_cnt++;
        end
        check("drop_if_no_refetch", 32'(busy_cnt), 32'h0);

        for (int i = 0; i < 40; i++) begin
            logic        r_dm, r_we;
            logic [1:0]  r_sz;
            logic [7:0]  r_a;
            logic [31:0] r_wd, r_exp;
            int          r_n;
            r_dm = 1'($urandom_range(0, 1));
            r_we = r_dm ? 1'($urandom_range(0, 1)) : 1'b0;
            r_sz = r_dm ? 2'($urandom_range(0, 3)) : 2'b10;
            r_a  = ($urandom_range(0, 3) == 0) ? 8'(8'hFC + $urandom_range(0, 3)) : 8'($urandom);
            r_wd = $urandom;
            r_n  = r_dm ? nb(r_sz) : 4;
            r_exp = r_we ? 32'h0 : model_load(r_a, r_n);
            do_txn($sformatf("rnd%0d", i), r_dm, r_we, r_sz, r_a, r_wd, r_exp, r_n + 1);
            if (r_we) model_store(r_a, r_n, r_wd);
        end

        // Reset lands while the second byte of a word store is on the bus.
        wd = 32'hA1B2C3D4;
        wait_idle();
        dm_req = 1'b1; dm_we = 1'b1; dm_size = 2'b10; dm_addr = 8'h40; dm_wdata = wd;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_mid_addr", 32'(mem_addr), 32'h41);
        check("rst_mid_we", 32'(mem_we), 32'h1);
        rst = 1'b1;
        dm_req = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_we_off", 32'(mem_we), 32'h0);
        check("rst_mid_done", 32'(dm_done), 32'h0);
        rst = 1'b0;
        model_store(8'h40, 2, wd);
        last_dm = 1'b0; exp_if = 32'h0; exp_dm = 32'h0;
        check("rst_mid_if_rdata", if_rdata, 32'h0);
        done_cnt = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (dm_done) done_cnt++;
        end
        check("rst_mid_no_done", 32'(done_cnt), 32'h0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_mid_byte%0d", i), 32'(mem[8'(8'h40 + i)]), 32'(ref_mem[8'(8'h40 + i)]));
        end
        do_txn("post_rst_load", 1'b1, 1'b0, 2'b10, 8'h40, 32'h0, model_load(8'h40, 4), 5);

        c = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) c++;
        check("mem_image_diffs", 32'(c), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
